// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an RV32M issue stage and the multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a fixed 32-iteration latency.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | one shift-add or restoring-divide step per edge, counter 0..31
// DONE  | result valid, done pulses for this single cycle
//
// Operands are held as magnitudes with separate sign flags, so the same
// unsigned datapath serves every funct3; signs are applied after the last step.
// acc holds {high product, multiplier} for multiply and {remainder, quotient}
// for divide, which lets both algorithms share one 64-bit register.
module muldiv_unit (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  f3;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] acc;
  logic [31:0] result_q;
  logic        busy_q;
  logic        done_q;

  logic        in_a_sgn;
  logic        in_b_sgn;
  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;

  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_nxt;
  logic [63:0] acc_nxt;

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] a_orig;
  logic [31:0] res_nxt;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Decode operand signedness from funct3 and form magnitudes of the incoming operands.
  always_comb begin
    in_a_sgn = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    in_b_sgn = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    in_neg_a = in_a_sgn & bus.op_a[31];
    in_neg_b = in_b_sgn & bus.op_b[31];
    in_a_mag = in_neg_a ? (~bus.op_a + 32'd1) : bus.op_a;
    in_b_mag = in_neg_b ? (~bus.op_b + 32'd1) : bus.op_b;
  end

  // One iteration of shift-add multiply or restoring divide on the magnitudes.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? a_mag : 32'd0)};
    mul_nxt   = {mul_sum, acc[31:1]};
    div_shift = acc[63:31];
    div_diff  = div_shift - {1'b0, b_mag};
    // A borrow out of bit 32 means the divisor did not fit: restore the shifted value.
    div_nxt   = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0],  acc[30:0], 1'b1};
    acc_nxt   = f3[2] ? div_nxt : mul_nxt;
  end

  // Sign fix-up and funct3 result selection, applied to the final iteration's value.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? (~acc_nxt + 64'd1) : acc_nxt;
    quo_fix  = (neg_a ^ neg_b) ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
    rem_fix  = neg_a ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
    a_orig   = neg_a ? (~a_mag + 32'd1) : a_mag;
    res_nxt  = 32'd0;
    case (f3)
      3'b000:                 res_nxt = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: res_nxt = prod_fix[63:32];
      3'b100, 3'b101:         res_nxt = (b_mag == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
      default:                res_nxt = (b_mag == 32'd0) ? a_orig : rem_fix;
    endcase
  end

  // Control FSM and datapath registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      f3       <= 3'd0;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      acc      <= 64'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            f3     <= bus.funct3;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            acc    <= {32'd0, (bus.funct3[2] ? in_a_mag : in_b_mag)};
            cnt    <= 5'd0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_q <= res_nxt;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 operand, driven from register-file rd1.
REQ-007 op_b  input  32  rs2 operand, driven from register-file rd2.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  32  registered result, written to the register file via wr_data.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE; no other state is reachable.
REQ-012 IDLE with start=1 at edge N: capture op_a, op_b and funct3; load iteration counter with 0; enter CALC.
REQ-013 CALC: one iteration per edge for exactly 32 edges (N+1..N+32); the counter increments 0..31; the edge with counter=31 enters DONE.
REQ-014 DONE: done=1 and result valid for the cycle after edge N+32; the next edge returns to IDLE with done=0.
REQ-015 Latency SHALL be fixed for all funct3 values and operands, including special cases: the done cycle begins 32 edges after the accepting edge.
REQ-016 start, op_a, op_b and funct3 SHALL be ignored while busy=1; captured operands are immune to input changes after edge N.
REQ-017 Multiply: unsigned shift-add on operand magnitudes, 64-bit accumulator, sign fix-up applied after the last iteration.
REQ-018 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats op_a signed and op_b unsigned; MULHU/DIVU/REMU treat both unsigned.
REQ-019 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-020 Divide: restoring, one quotient bit per iteration on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 Divide by zero (op_b=0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a unchanged.
REQ-022 Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0x00000000.
REQ-023 result SHALL update only on the edge entering DONE and hold its value until the next DONE entry or reset.
REQ-024 start=1 while in DONE SHALL be ignored; a new request is accepted only from IDLE.
REQ-025 done SHALL never be high for two consecutive cycles.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, result=0x00000000 and clear the counter and internal registers; this takes priority over start.
REQ-027 rst asserted during CALC or DONE SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL run normally with full latency.

Verification
REQ-028 MUL 7 x -3 (op_a=0x00000007, op_b=0xFFFFFFFD) -> done exactly 32 edges after accept, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU same operands -> 0x00000006.
REQ-029 MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA; REMU 0x80000000/3 -> 0x00000002.
REQ-031 Divide by zero with op_a=0x12345678: DIVU -> 0xFFFFFFFF; REM -> 0x12345678. Overflow: DIV 0x80000000/-1 -> 0x80000000; REM -> 0x00000000. All at standard latency.
REQ-032 Change op_a and op_b and pulse start mid-CALC -> result unaffected, no second done; start held high continuously -> back-to-back ops with exactly one IDLE cycle between done pulses.
REQ-033 Assert rst at iteration 15 -> next cycle busy=0, done=0, result=0; no done pulse follows; a subsequent MULHU 0xFFFFFFFF x 0xFFFFFFFF completes with result 0xFFFFFFFE.
